// File: rtl/ae_program_sequencer.sv
// Start/done controlled program sequencer for the autoencoder datapath: fetches from a
// synchronous instruction memory, runs single-level LOOP/ENDL blocks, and issues all other words.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | imem_addr presented; also carries a pending issue, held here while stall=1
// EXEC  | imem_data valid; decode and either consume a control word or issue
// DONE  | one-cycle done pulse, busy drops on exit
module ae_program_sequencer #(
    parameter int         ADDR_W  = 16,
    parameter logic [3:0] OP_HALT = 4'hF,
    parameter logic [3:0] OP_LOOP = 4'hE,
    parameter logic [3:0] OP_ENDL = 4'hD
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic              issue_valid,
    output logic [15:0]       issue_instr,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] loop_start;
    logic [11:0]       loop_cnt;
    logic              loop_active;

    logic [3:0]        op;
    logic [11:0]       loop_init;
    logic [ADDR_W-1:0] pc_inc;

    // imem_addr doubles as the program counter, so the address is already registered
    // when FETCH begins and the memory returns data in EXEC.
    assign op        = imem_data[15:12];
    assign loop_init = (imem_data[11:0] == 12'd0) ? 12'd1 : imem_data[11:0];
    assign pc_inc    = imem_addr + ADDR_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            imem_addr   <= '0;
            issue_valid <= 1'b0;
            issue_instr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            loop_start  <= '0;
            loop_cnt    <= '0;
            loop_active <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        imem_addr <= start_addr;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!(issue_valid && stall)) begin
                        issue_valid <= 1'b0;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_HALT: begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                        OP_LOOP: begin
                            if (loop_active) begin
                                error <= 1'b1;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                loop_start  <= pc_inc;
                                loop_cnt    <= loop_init;
                                loop_active <= 1'b1;
                                imem_addr   <= pc_inc;
                                state       <= S_FETCH;
                            end
                        end
                        OP_ENDL: begin
                            if (!loop_active) begin
                                error <= 1'b1;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else if (loop_cnt > 12'd1) begin
                                loop_cnt  <= loop_cnt - 12'd1;
                                imem_addr <= loop_start;
                                state     <= S_FETCH;
                            end else begin
                                loop_active <= 1'b0;
                                imem_addr   <= pc_inc;
                                state       <= S_FETCH;
                            end
                        end
                        default: begin
                            // The issue cycle overlaps the next fetch to keep two cycles per word.
                            issue_instr <= imem_data;
                            issue_valid <= 1'b1;
                            imem_addr   <= pc_inc;
                            state       <= S_FETCH;
                        end
                    endcase
                end
                S_DONE: begin
                    busy        <= 1'b0;
                    loop_active <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ae_program_sequencer.sv
// Bench for ae_program_sequencer: a program interpreter predicts the issue stream, error
// and busy length; a negedge monitor compares every busy cycle; directed runs pin exact timing.
module tb_ae_program_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] start_addr;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        issue_valid;
    logic [15:0] issue_instr;
    logic        stall;
    logic        busy;
    logic        done;
    logic        error;

    ae_program_sequencer #(.ADDR_W(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .start_addr  (start_addr),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .issue_valid (issue_valid),
        .issue_instr (issue_instr),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [0:65535];
    always @(posedge clock) imem_data <= mem[imem_addr];

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_words [$];
    int          exp_cyc;
    logic        exp_err;

    int          ptr;
    int          run_cyc;
    int          done_cnt = 0;
    logic        prev_stalled;
    logic [15:0] prev_instr;

    logic        cap_iv [16];
    logic [15:0] cap_ii [16];
    logic        cap_bz [16];
    logic        cap_dn [16];
    logic [15:0] cap_ad [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp_v);
        end
    endtask

    // Walks the program as the datapath sees it: which words issue, whether it errors,
    // and how many busy cycles it takes (2 per fetched word, 1 for DONE, plus stalls).
    task automatic model_run(input logic [15:0] addr, input int stalls);
        logic [15:0] pc, ls, w;
        logic [11:0] cnt;
        logic        active;
        int          fetched;
        bit          fin;
        pc = addr; ls = '0; cnt = '0; active = 1'b0; fetched = 0; fin = 1'b0;
        exp_words.delete();
        exp_err = 1'b0;
        while (!fin && fetched < 4096) begin
            w = mem[pc];
            fetched++;
            case (w[15:12])
                4'hF: fin = 1'b1;
                4'hE: begin
                    if (active) begin
                        exp_err = 1'b1; fin = 1'b1;
                    end else begin
                        ls = pc + 16'd1;
                        cnt = (w[11:0] == 12'd0) ? 12'd1 : w[11:0];
                        active = 1'b1;
                        pc = pc + 16'd1;
                    end
                end
                4'hD: begin
                    if (!active) begin
                        exp_err = 1'b1; fin = 1'b1;
                    end else if (cnt > 12'd1) begin
                        cnt = cnt - 12'd1;
                        pc = ls;
                    end else begin
                        active = 1'b0;
                        pc = pc + 16'd1;
                    end
                end
                default: begin
                    exp_words.push_back(w);
                    pc = pc + 16'd1;
                end
            endcase
        end
        exp_cyc = 2 * fetched + 1 + stalls;
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            ptr = 0; run_cyc = 0; prev_stalled = 1'b0;
        end else if (!busy) begin
            chk("idle_issue", issue_valid, 1'b0);
            chk("idle_done", done, 1'b0);
            ptr = 0; run_cyc = 0; prev_stalled = 1'b0;
        end else begin
            run_cyc++;
            if (issue_valid) begin
                if (prev_stalled) chk("stall_hold", issue_instr, prev_instr);
                if (ptr < exp_words.size()) begin
                    chk("issue_word", issue_instr, exp_words[ptr]);
                end else begin
                    checks++; errors++;
                    $display("FAIL issue_extra: got %0h, want no issue", issue_instr);
                end
                prev_stalled = stall;
                prev_instr   = issue_instr;
                if (!stall) ptr++;
            end else begin
                prev_stalled = 1'b0;
            end
            if (!done) chk("error_clear", error, 1'b0);
            if (done) begin
                chk("busy_len", run_cyc, exp_cyc);
                chk("issue_count", ptr, exp_words.size());
                chk("error_flag", error, exp_err);
                done_cnt++;
            end
        end
    end

    task automatic do_start(input logic [15:0] a);
        @(posedge clock); #1;
        start = 1'b1; start_addr = a;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Sample k is taken at the falling edge after the k-th rising edge following start.
    task automatic capture(input int n, input int drop_edge);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            cap_iv[k] = issue_valid; cap_ii[k] = issue_instr;
            cap_bz[k] = busy; cap_dn[k] = done; cap_ad[k] = imem_addr;
            if (k + 1 == drop_edge) begin
                @(posedge clock); #1;
                stall = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input int base);
        int t = 0;
        while (done_cnt == base && t < 300) begin
            @(posedge clock);
            t++;
        end
        chk("done_seen", done_cnt - base, 1);
        repeat (2) @(posedge clock);
    endtask

    task automatic run_prog(input logic [15:0] a);
        int base;
        base = done_cnt;
        model_run(a, 0);
        do_start(a);
        wait_done(base);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset_n = 1'b0; start = 1'b0; start_addr = '0; stall = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'hF000;
        mem[16'h0000] = 16'h1123; mem[16'h0001] = 16'h2456; mem[16'h0002] = 16'hF000;
        mem[16'h0010] = 16'h3111; mem[16'h0011] = 16'h4222; mem[16'h0012] = 16'hF000;
        mem[16'h0020] = 16'hE003; mem[16'h0021] = 16'h1AAA; mem[16'h0022] = 16'h2BBB;
        mem[16'h0023] = 16'hD000; mem[16'h0024] = 16'hF000;
        mem[16'h0030] = 16'hE000; mem[16'h0031] = 16'h5CCC; mem[16'h0032] = 16'hD000;
        mem[16'h0033] = 16'hF000;
        mem[16'h0040] = 16'h6DDD; mem[16'h0041] = 16'hD000;
        mem[16'h0050] = 16'hE002; mem[16'h0051] = 16'hE001;
        mem[16'h0060] = 16'hE005; mem[16'h0061] = 16'h7777; mem[16'h0062] = 16'hD000;
        mem[16'h0063] = 16'hF000;

        repeat (3) @(posedge clock);
        #2;
        chk("rst_issue_valid", issue_valid, 1'b0);
        chk("rst_issue_instr", issue_instr, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_imem_addr", imem_addr, 16'h0000);
        reset_n = 1'b1;

        // Straight-line program: issues two and four edges after start, done at six.
        base = done_cnt;
        model_run(16'h0000, 0);
        chk("model_t1_len", exp_words.size(), 2);
        chk("model_t1_cyc", exp_cyc, 7);
        do_start(16'h0000);
        capture(9, 0);
        chk("t1_addr0", cap_ad[0], 16'h0000);
        chk("t1_busy0", cap_bz[0], 1'b1);
        chk("t1_iv1", cap_iv[1], 1'b0);
        chk("t1_iv2", cap_iv[2], 1'b1);
        chk("t1_ii2", cap_ii[2], 16'h1123);
        chk("t1_iv3", cap_iv[3], 1'b0);
        chk("t1_iv4", cap_iv[4], 1'b1);
        chk("t1_ii4", cap_ii[4], 16'h2456);
        chk("t1_done5", cap_dn[5], 1'b0);
        chk("t1_done6", cap_dn[6], 1'b1);
        chk("t1_busy6", cap_bz[6], 1'b1);
        chk("t1_busy7", cap_bz[7], 1'b0);
        chk("t1_done7", cap_dn[7], 1'b0);
        wait_done(base);

        // Three stalled cycles on the first issue: visible four cycles, fetch held.
        base = done_cnt;
        model_run(16'h0010, 3);
        chk("model_t2_cyc", exp_cyc, 10);
        stall = 1'b1;
        do_start(16'h0010);
        capture(12, 5);
        chk("t2_iv5", cap_iv[5], 1'b1);
        chk("t2_ii5", cap_ii[5], 16'h3111);
        chk("t2_fetch_held", cap_ad[5], 16'h0011);
        chk("t2_iv6", cap_iv[6], 1'b0);
        chk("t2_iv7", cap_iv[7], 1'b1);
        chk("t2_ii7", cap_ii[7], 16'h4222);
        chk("t2_done9", cap_dn[9], 1'b1);
        wait_done(base);

        model_run(16'h0020, 0);
        chk("model_t3_len", exp_words.size(), 6);
        chk("model_t3_word2", exp_words[2], 16'h1AAA);
        chk("model_t3_cyc", exp_cyc, 23);
        run_prog(16'h0020);

        model_run(16'h0030, 0);
        chk("model_loop0_len", exp_words.size(), 1);
        run_prog(16'h0030);

        model_run(16'h0040, 0);
        chk("model_bare_endl_err", exp_err, 1'b1);
        run_prog(16'h0040);
        chk("error_sticky", error, 1'b1);

        run_prog(16'h0050);
        chk("nest_error", error, 1'b1);

        run_prog(16'h0030);
        chk("error_cleared", error, 1'b0);

        // Asynchronous reset while a looped issue is stalled, then restart at 5.
        model_run(16'h0060, 0);
        stall = 1'b1;
        do_start(16'h0060);
        repeat (6) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_issue_valid", issue_valid, 1'b0);
        chk("arst_issue_instr", issue_instr, 16'h0000);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_error", error, 1'b0);
        chk("arst_imem_addr", imem_addr, 16'h0000);
        @(posedge clock); #1;
        stall = 1'b0;
        #2 reset_n = 1'b1;
        mem[16'h0005] = 16'h8888; mem[16'h0006] = 16'hF000;
        base = done_cnt;
        model_run(16'h0005, 0);
        do_start(16'h0005);
        @(negedge clock);
        chk("restart_addr", imem_addr, 16'h0005);
        wait_done(base);

        // Program at the top of the address space; a start pulse while busy is dropped.
        mem[16'hFFFF] = 16'h9999; mem[16'h0000] = 16'hF000;
        base = done_cnt;
        model_run(16'hFFFF, 0);
        chk("model_wrap_cyc", exp_cyc, 5);
        do_start(16'hFFFF);
        @(posedge clock); #1;
        start = 1'b1; start_addr = 16'h0010;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        chk("wrap_addr", imem_addr, 16'h0000);
        chk("wrap_issue", issue_instr, 16'h9999);
        wait_done(base);
        repeat (4) @(negedge clock);
        chk("no_queued_start", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
